// File: rtl/tcb_lib_demultiplexer_if.sv
// tcb_lib_demultiplexer_if: TCB bus bundle of N parallel ports.
//   vld/rdy/wen/adr/ben/wdt : request (manager -> subordinate), rdy returned
//   rdt/err                 : response (subordinate -> manager)
//   master modport drives requests, slave modport drives rdy and responses.
interface tcb_lib_demultiplexer_if #(
  parameter int N   = 1,
  parameter int ADR = 32,
  parameter int DAT = 32,
  parameter int BEN = DAT/8
);
  logic [N-1:0]          vld, rdy, wen, err;
  logic [N-1:0][ADR-1:0] adr;
  logic [N-1:0][BEN-1:0] ben;
  logic [N-1:0][DAT-1:0] wdt, rdt;
  modport master (output vld, wen, adr, ben, wdt, input rdy, rdt, err);
  modport slave  (input vld, wen, adr, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/tcb_lib_demultiplexer.sv
// tcb_lib_demultiplexer: routes one TCB manager stream to MPN subordinate ports by address.
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   sub  : upstream port (N=1), slave side
//   man  : downstream ports (N=MPN), master side; request fields broadcast, vld one-hot
//   TCB_LIB_DEMULTIPLEXER_ERR_EN: when defined, unmapped addresses hit an internal
//   error slot (select code MPN) answering err=1; otherwise they decode to port 0.
module tcb_lib_demultiplexer #(
  parameter int DLY = 1,
  parameter int ADR = 32,
  parameter int DAT = 32,
  parameter int BEN = DAT/8,
  parameter int MPN = 3,
  parameter logic [MPN-1:0][ADR-1:0] BAS = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [MPN-1:0][ADR-1:0] MSK = {MPN{ADR'(32'hF000_0000)}}
)(
  input logic clk,
  input logic rst,
  tcb_lib_demultiplexer_if.slave  sub,
  tcb_lib_demultiplexer_if.master man
);
`ifdef TCB_LIB_DEMULTIPLEXER_ERR_EN
  localparam int MPL = $clog2(MPN+1);
  localparam bit ERR = 1'b1;
  localparam logic [MPL-1:0] DEF = MPL'(MPN);
`else
  localparam int MPL = $clog2(MPN);
  localparam bit ERR = 1'b0;
  localparam logic [MPL-1:0] DEF = '0;
`endif
  logic [MPL-1:0] sel, rsp_sel;
  logic err_sel, trn, rsp_vld, rsp_err;
  // descending scan so the lowest matching port wins
  always_comb begin
    sel = DEF;
    for (int i = MPN-1; i >= 0; i--)
      if ((sub.adr[0] & MSK[i]) == BAS[i]) sel = MPL'(i);
  end
  assign err_sel    = ERR && (sel == DEF);
  assign sub.rdy[0] = err_sel ? 1'b1 : man.rdy[sel];
  assign trn        = sub.vld[0] & sub.rdy[0];
  always_comb begin
    for (int i = 0; i < MPN; i++) begin
      man.vld[i] = sub.vld[0] && !err_sel && (sel == MPL'(i));
      man.wen[i] = sub.wen[0];
      man.adr[i] = sub.adr[0];
      man.ben[i] = sub.ben[0];
      man.wdt[i] = sub.wdt[0];
    end
  end
  generate
    if (DLY > 0) begin : g_pipe
      logic [DLY-1:0]          vld_q, vld_d;
      logic [DLY-1:0][MPL-1:0] sel_q, sel_d;
      always_comb begin
        vld_d[0] = trn;
        sel_d[0] = sel;
        for (int k = 1; k < DLY; k++) begin
          vld_d[k] = vld_q[k-1];
          sel_d[k] = sel_q[k-1];
        end
      end
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          vld_q <= '0;
          sel_q <= '0;
        end else begin
          vld_q <= vld_d;
          sel_q <= sel_d;
        end
      assign rsp_vld = vld_q[DLY-1];
      assign rsp_sel = sel_q[DLY-1];
    end else begin : g_comb
      assign rsp_vld = trn;
      assign rsp_sel = sel;
    end
  endgenerate
  assign rsp_err    = ERR && (rsp_sel == DEF);
  // idle stages and the error slot force zero data so nothing undefined leaks upstream
  assign sub.rdt[0] = (rsp_vld && !rsp_err) ? man.rdt[rsp_sel] : '0;
  assign sub.err[0] = rsp_vld && (rsp_err || man.err[rsp_sel]);
endmodule

// File: tb/tb_tcb_lib_demultiplexer.sv
// tb_tcb_lib_demultiplexer: random and directed traffic into DLY=0/1/2 instances against a transfer-history model.
module tb_tcb_lib_demultiplexer;
  localparam int ADR = 32, DAT = 32, MPN = 3, NC = 1024;
`ifdef TCB_LIB_DEMULTIPLEXER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic vld = 1'b0, wen = 1'b0;
  logic [ADR-1:0] adr = '0;
  logic [DAT-1:0] wdt = '0;
  logic [3:0] ben = '0;
  logic [MPN-1:0] mrdy = '1, merr = '0;
  logic [MPN-1:0][DAT-1:0] mrdt = '0;
  logic rdy_o[3], err_o[3];
  logic [DAT-1:0] rdt_o[3];
  logic [MPN-1:0] mvld_o[3];
  logic [ADR-1:0] madr_o[3];
  for (genvar d = 0; d < 3; d++) begin : g
    tcb_lib_demultiplexer_if #(.N(1), .ADR(ADR), .DAT(DAT)) s();
    tcb_lib_demultiplexer_if #(.N(MPN), .ADR(ADR), .DAT(DAT)) m();
    assign s.vld = vld;
    assign s.wen = wen;
    assign s.adr = adr;
    assign s.ben = ben;
    assign s.wdt = wdt;
    assign m.rdy = mrdy;
    assign m.rdt = mrdt;
    assign m.err = merr;
    assign rdy_o[d]  = s.rdy[0];
    assign rdt_o[d]  = s.rdt[0];
    assign err_o[d]  = s.err[0];
    assign mvld_o[d] = m.vld;
    assign madr_o[d] = m.adr[MPN-1];
    tcb_lib_demultiplexer #(.DLY(d), .ADR(ADR), .DAT(DAT), .MPN(MPN)) dut (
      .clk(clk), .rst(rst), .sub(s), .man(m));
  end
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit hv[NC];
  int hp[NC];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask
  // regions are 256MB slices: top nibble 0/1/2 -> port 0/1/2, anything else unmapped
  function automatic int dec(input logic [ADR-1:0] a);
    int r = int'(a >> 28);
    return r < MPN ? r : (ERR ? MPN : 0);
  endfunction
  task automatic step(input logic v, input logic w, input logic [ADR-1:0] a,
                      input logic [MPN-1:0] r, input logic rs);
    int p, j;
    bit ev;
    logic [DAT-1:0] erdt;
    logic eerr;
    vld = v; wen = w; adr = a; mrdy = r; rst = rs;
    wdt = $urandom; ben = 4'($urandom);
    for (int i = 0; i < MPN; i++) begin
      mrdt[i] = $urandom;
      merr[i] = ($urandom_range(0, 3) == 0);
    end
    p = dec(a);
    hv[cyc] = rs && v && (p == MPN || r[p]);
    hp[cyc] = p;
    if (!rs) for (int k = 1; k <= 2; k++) if (cyc >= k) hv[cyc-k] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      j = cyc - d;
      ev = (j >= 0) && hv[j];
      erdt = (ev && hp[j] < MPN) ? mrdt[hp[j]] : '0;
      eerr = ev && (hp[j] == MPN || merr[hp[j]]);
      chk($sformatf("rdy%0d", d), rdy_o[d], (p == MPN) ? 1'b1 : r[p]);
      chk($sformatf("mvld%0d", d), mvld_o[d], (v && p < MPN) ? MPN'(1 << p) : '0);
      chk($sformatf("madr%0d", d), madr_o[d], a);
      chk($sformatf("rdt%0d", d), rdt_o[d], erdt);
      chk($sformatf("err%0d", d), err_o[d], eerr);
    end
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    @(negedge clk);
    repeat (2) step(0, 0, '0, '1, 0);
    step(1, 1, 32'h1000_0004, '1, 1);
    step(1, 0, 32'h0000_0000, '1, 1);
    step(1, 0, 32'h1000_0000, '1, 1);
    step(1, 0, 32'h2000_0000, '1, 1);
    step(1, 0, 32'h3000_0000, '1, 1);
    step(0, 0, '0, '1, 1);
    repeat (3) step(1, 0, 32'h2000_0000, 3'b011, 1);
    step(1, 0, 32'h2000_0000, 3'b111, 1);
    repeat (2) step(0, 0, '0, '1, 1);
    step(1, 0, 32'h1000_0008, '1, 1);
    step(1, 0, 32'h2000_000C, '1, 1);
    repeat (2) step(0, 0, '0, '1, 0);
    repeat (3) step(0, 0, '0, '1, 1);
    repeat (500) begin
      logic rs;
      rs = ($urandom_range(0, 49) != 0);
      step(rs && ($urandom_range(0, 3) != 0), 1'($urandom),
           {4'($urandom_range(0, 3)), 28'($urandom)},
           {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)}, rs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
